muldiv_seq: RTL and testbench

- Parametrised iterative multiply/divide unit feeding the HI/LO registers of the multicycle datapath.
- Replaces the separate fixed-32-bit mult and div blocks with one shared engine.
- Adds: width parameter, signed/unsigned mode per operation, divide-by-zero flag, explicit start/busy/done handshake.
- The control FSM pulses start, waits for done, then loads hi into the HI register and lo into the LO register.

---
 rtl/muldiv_seq.sv | 158 +++++++++++++++
 tb/tb_muldiv_seq.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide engine for the HI/LO registers: shift-add multiply
// and restoring divide, one bit per cycle, signed or unsigned per operation.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic               isDiv_q, isDiv_d;
    logic               negQuo_q, negQuo_d;
    logic               negRem_q, negRem_d;
    logic [WIDTH-1:0]   magM_q, magM_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               divZero_q, divZero_d;
    logic               done_q, done_d;

    logic               signA, signB;
    logic [WIDTH-1:0]   absA, absB;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic               divFits;
    logic [WIDTH-1:0]   divRem;
    logic [2*WIDTH-1:0] prodFix;

    // op[0] set means unsigned, so sign bits only count for the signed ops
    assign signA = ~op[0] & a[WIDTH-1];
    assign signB = ~op[0] & b[WIDTH-1];
    assign absA  = signA ? -a : a;
    assign absB  = signB ? -b : b;

    // Multiply keeps {partial product, remaining multiplier bits} in acc_q;
    // divide keeps {partial remainder, dividend bits becoming quotient bits}.
    assign mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, magM_q} : '0);
    assign divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign divFits  = divShift >= {1'b0, magM_q};
    assign divRem   = WIDTH'(divShift - {1'b0, magM_q});
    assign prodFix  = negQuo_q ? -acc_q : acc_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            isDiv_q   <= 1'b0;
            negQuo_q  <= 1'b0;
            negRem_q  <= 1'b0;
            magM_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            divZero_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            isDiv_q   <= isDiv_d;
            negQuo_q  <= negQuo_d;
            negRem_q  <= negRem_d;
            magM_q    <= magM_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divZero_q <= divZero_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        isDiv_d   = isDiv_q;
        negQuo_d  = negQuo_q;
        negRem_d  = negRem_q;
        magM_d    = magM_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divZero_d = divZero_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    isDiv_d  = op[1];
                    negQuo_d = signA ^ signB;
                    negRem_d = signA;
                    cnt_d    = '0;
                    if (op[1] && (b == '0)) begin
                        // Divide by zero answers straight away so done follows the start edge
                        hi_d      = a;
                        lo_d      = '1;
                        divZero_d = 1'b1;
                        done_d    = 1'b1;
                    end else if (op[1]) begin
                        acc_d   = {{WIDTH{1'b0}}, absA};
                        magM_d  = absB;
                        state_d = CALC;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, absB};
                        magM_d  = absA;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (isDiv_q) begin
                    acc_d = divFits ? {divRem, acc_q[WIDTH-2:0], 1'b1}
                                    : {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mulSum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (isDiv_q) begin
                    lo_d = negQuo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    hi_d = prodFix[2*WIDTH-1:WIDTH];
                    lo_d = prodFix[WIDTH-1:0];
                end
                divZero_d = 1'b0;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = divZero_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised and directed bench for muldiv_seq at WIDTH=32 and WIDTH=8,
// checked against an arithmetic reference model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        Reset;
    logic        start32, start8;
    logic [1:0]  op32, op8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic        busy32, done32, dz32, busy8, done8, dz8;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;

    int total = 0;
    int bad   = 0;

    localparam int LIMIT = 200;

    muldiv_seq #(.WIDTH(32)) dut32 (
        .Clk(clk), .Reset(Reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .div_zero(dz32)
    );

    muldiv_seq #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(Reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8)
    );

    always #5 clk = ~clk;

    // Reference result {div_zero, hi, lo} straight from the arithmetic definition
    function automatic logic [64:0] model(input int w, input logic [1:0] o,
                                          input logic [31:0] x, input logic [31:0] y);
        longint mask, ux, uy, sx, sy, p, q, r;
        logic [31:0] rh, rl;
        logic rdz;
        mask = (longint'(1) << w) - 1;
        ux = longint'(x) & mask;
        uy = longint'(y) & mask;
        sx = ux;
        sy = uy;
        if (o[0] == 1'b0 && ((ux >> (w - 1)) & 1) == 1) sx = ux - (longint'(1) << w);
        if (o[0] == 1'b0 && ((uy >> (w - 1)) & 1) == 1) sy = uy - (longint'(1) << w);
        rdz = 1'b0;
        if (o[1] == 1'b0) begin
            p  = (o[0] == 1'b0) ? sx * sy : ux * uy;
            rh = 32'((p >> w) & mask);
            rl = 32'(p & mask);
        end else if (uy == 0) begin
            rdz = 1'b1;
            rh  = 32'(ux);
            rl  = 32'(mask);
        end else begin
            if (o[0] == 1'b0) begin
                q = sx / sy;
                r = sx % sy;
            end else begin
                q = ux / uy;
                r = ux % uy;
            end
            rh = 32'(r & mask);
            rl = 32'(q & mask);
        end
        return {rdz, rh, rl};
    endfunction

    function automatic int expLatency(input int w, input logic [1:0] o, input logic [31:0] y);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        return (o[1] && ((y & m) == 0)) ? 1 : w + 2;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m;
        logic [31:0] r;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        case ($urandom_range(0, 6))
            0:       r = 32'd0;
            1:       r = 32'd1 << (w - 1);
            2:       r = m;
            3:       r = 32'd1;
            default: r = $urandom & m;
        endcase
        return r;
    endfunction

    // Issues one operation from IDLE and waits (bounded) for done
    task automatic runOp(input bit sel, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, output logic [31:0] rh, output logic [31:0] rl,
                         output logic rdz, output int cyc, output int busyCnt,
                         output bit overlap, output bit timedOut);
        if (!sel) begin
            start32 = 1'b1; op32 = o; a32 = x; b32 = y;
        end else begin
            start8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0];
        end
        @(posedge clk); #1;
        start32 = 1'b0; start8 = 1'b0;
        op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
        op8  = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        cyc = 1; busyCnt = 0; overlap = 1'b0;
        while (!(sel ? done8 : done32) && cyc < LIMIT) begin
            if (sel ? busy8 : busy32) busyCnt++;
            @(posedge clk); #1;
            cyc++;
        end
        timedOut = (cyc >= LIMIT);
        overlap  = sel ? (busy8 & done8) : (busy32 & done32);
        rh  = sel ? {24'd0, hi8} : hi32;
        rl  = sel ? {24'd0, lo8} : lo32;
        rdz = sel ? dz8 : dz32;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        start32 = 1'b0; start8 = 1'b0;
        op32 = 2'd0; op8 = 2'd0; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b0;
        total++;
        if ({busy32, done32, dz32, hi32, lo32} !== 67'd0) begin
            bad++;
            $display("[TB] FAIL reset32: got busy=%b done=%b dz=%b hi=%h lo=%h expected all zero",
                     busy32, done32, dz32, hi32, lo32);
        end
        total++;
        if ({busy8, done8, dz8, hi8, lo8} !== 19'd0) begin
            bad++;
            $display("[TB] FAIL reset8: got busy=%b done=%b dz=%b hi=%h lo=%h expected all zero",
                     busy8, done8, dz8, hi8, lo8);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  tOp [8] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd0};
        logic [31:0] tA  [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF9,
                                 32'd7, 32'h8000_0000, 32'h0000_1234, 32'd2};
        logic [31:0] tB  [8] = '{32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2,
                                 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd3};
        logic [31:0] tHi [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF,
                                 32'd1, 32'd0, 32'h0000_1234, 32'd0};
        logic [31:0] tLo [8] = '{32'hFFFF_FFF1, 32'h0000_0001, 32'd0, 32'hFFFF_FFFD,
                                 32'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd6};
        logic        tDz [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int          tLat[8] = '{34, 34, 34, 34, 34, 34, 1, 34};
        logic [31:0] rh, rl;
        logic        rdz;
        int          cyc, busyCnt;
        bit          overlap, timedOut;
        for (int i = 0; i < 8; i++) begin
            runOp(1'b0, tOp[i], tA[i], tB[i], rh, rl, rdz, cyc, busyCnt, overlap, timedOut);
            total++;
            if (timedOut || cyc !== tLat[i]) begin
                bad++;
                $display("[TB] FAIL directed%0d latency: got %0d expected %0d", i, cyc, tLat[i]);
            end
            total++;
            if ({rdz, rh, rl} !== {tDz[i], tHi[i], tLo[i]}) begin
                bad++;
                $display("[TB] FAIL directed%0d result: got dz=%b hi=%h lo=%h expected dz=%b hi=%h lo=%h",
                         i, rdz, rh, rl, tDz[i], tHi[i], tLo[i]);
            end
            total++;
            if (busyCnt !== tLat[i] - 1 || overlap) begin
                bad++;
                $display("[TB] FAIL directed%0d busy: got %0d busy cycles overlap=%b expected %0d overlap=0",
                         i, busyCnt, overlap, tLat[i] - 1);
            end
        end
    endtask

    task automatic test_width8();
        logic [31:0] rh, rl;
        logic        rdz;
        int          cyc, busyCnt;
        bit          overlap, timedOut;
        runOp(1'b1, 2'd0, 32'h0000_00FD, 32'd5, rh, rl, rdz, cyc, busyCnt, overlap, timedOut);
        total++;
        if (timedOut || cyc !== 10 || busyCnt !== 9) begin
            bad++;
            $display("[TB] FAIL w8 latency: got done=%0d busy=%0d expected done=10 busy=9", cyc, busyCnt);
        end
        total++;
        if (rh !== 32'h0000_00FF || rl !== 32'h0000_00F1 || rdz !== 1'b0) begin
            bad++;
            $display("[TB] FAIL w8 mult: got hi=%h lo=%h dz=%b expected hi=ff lo=f1 dz=0", rh, rl, rdz);
        end
    endtask

    task automatic test_random(input bit sel, input int count);
        int          w;
        logic [1:0]  o;
        logic [31:0] x, y, rh, rl;
        logic        rdz;
        logic [64:0] e;
        int          cyc, busyCnt, lat;
        bit          overlap, timedOut;
        w = sel ? 8 : 32;
        for (int i = 0; i < count; i++) begin
            o = 2'($urandom_range(0, 3));
            x = pick(w);
            y = pick(w);
            e = model(w, o, x, y);
            lat = expLatency(w, o, y);
            runOp(sel, o, x, y, rh, rl, rdz, cyc, busyCnt, overlap, timedOut);
            total++;
            if ({rdz, rh, rl} !== e) begin
                bad++;
                $display("[TB] FAIL rand w%0d op=%0d a=%h b=%h: got dz=%b hi=%h lo=%h expected dz=%b hi=%h lo=%h",
                         w, o, x, y, rdz, rh, rl, e[64], e[63:32], e[31:0]);
            end
            total++;
            if (timedOut || cyc !== lat || busyCnt !== lat - 1 || overlap) begin
                bad++;
                $display("[TB] FAIL rand w%0d timing: got done=%0d busy=%0d overlap=%b expected done=%0d busy=%0d",
                         w, cyc, busyCnt, overlap, lat, lat - 1);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [64:0] e;
        int          cyc;
        e = model(32, 2'd0, 32'd1234, 32'd5678);
        start32 = 1'b1; op32 = 2'd0; a32 = 32'd1234; b32 = 32'd5678;
        @(posedge clk); #1;
        start32 = 1'b0;
        cyc = 1;
        while (!done32 && cyc < LIMIT) begin
            if (cyc == 10) begin
                start32 = 1'b1; op32 = 2'd3; a32 = 32'd99; b32 = 32'd0;
            end else begin
                start32 = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start32 = 1'b0;
        total++;
        if (cyc !== 34 || {dz32, hi32, lo32} !== e) begin
            bad++;
            $display("[TB] FAIL ignore_start: got done=%0d dz=%b hi=%h lo=%h expected done=34 dz=%b hi=%h lo=%h",
                     cyc, dz32, hi32, lo32, e[64], e[63:32], e[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x1, y1, x2, y2;
        logic [64:0] e1, e2;
        int          cyc;
        x1 = $urandom; y1 = $urandom;
        x2 = $urandom; y2 = $urandom_range(1, 1000);
        e1 = model(32, 2'd0, x1, y1);
        e2 = model(32, 2'd2, x2, y2);
        start32 = 1'b1; op32 = 2'd0; a32 = x1; b32 = y1;
        @(posedge clk); #1;
        op32 = 2'd2; a32 = x2; b32 = y2;
        cyc = 1;
        while (!done32 && cyc < LIMIT) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (cyc !== 34 || {dz32, hi32, lo32} !== e1) begin
            bad++;
            $display("[TB] FAIL b2b first: got done=%0d hi=%h lo=%h expected done=34 hi=%h lo=%h",
                     cyc, hi32, lo32, e1[63:32], e1[31:0]);
        end
        @(posedge clk); #1;
        start32 = 1'b0;
        cyc = 1;
        while (!done32 && cyc < LIMIT) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (cyc !== 34 || {dz32, hi32, lo32} !== e2) begin
            bad++;
            $display("[TB] FAIL b2b second: got done=%0d hi=%h lo=%h expected done=34 hi=%h lo=%h",
                     cyc, hi32, lo32, e2[63:32], e2[31:0]);
        end
    endtask

    task automatic test_reset_midop();
        int sawDone;
        start32 = 1'b1; op32 = 2'd2; a32 = 32'd100000; b32 = 32'd7;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (14) begin
            @(posedge clk); #1;
        end
        Reset = 1'b1;
        @(posedge clk); #1;
        Reset = 1'b0;
        total++;
        if ({busy32, done32, dz32, hi32, lo32} !== 67'd0) begin
            bad++;
            $display("[TB] FAIL reset_midop: got busy=%b done=%b hi=%h lo=%h expected all zero",
                     busy32, done32, hi32, lo32);
        end
        sawDone = 0;
        repeat (40) begin
            if (done32 || busy32) sawDone++;
            @(posedge clk); #1;
        end
        total++;
        if (sawDone !== 0) begin
            bad++;
            $display("[TB] FAIL reset_noDone: got %0d busy/done cycles expected 0", sawDone);
        end
    endtask

    initial begin
        $display("[TB] muldiv_seq bench starting");
        test_reset();
        test_directed();
        test_width8();
        test_random(1'b0, 40);
        test_random(1'b1, 40);
        test_ignore_start();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
